// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and 20 MHz timing constants for the 10BASE-T transmit path
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NLP,
        ST_FSTART,
        ST_FRAME,
        ST_IFG
    } tx_sched_state_t;

    // 20 MHz PHY clock timing
    localparam int NLP_PERIOD    = 320000;  // 16 ms between normal link pulses
    localparam int IFG_CYCLES    = 192;     // 9.6 us inter-frame gap
    localparam int NLP_HOLD      = 4;       // 2-cycle pulse plus 2 guard cycles
    localparam int START_TIMEOUT = 64;      // frame_go to frame_busy allowance

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width of a counter holding 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_tx_timer.sv
// rtl/eth_tx_timer.sv - loadable down-counter with a done flag, shared state-timer
module eth_tx_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over counting; the counter parks at zero once expired
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loading N-1 makes done rise on the Nth cycle after the load
    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - schedules link pulses and frame starts on the 10BASE-T TX line
module eth_tx_sched #(
    parameter int NLP_PERIOD    = eth_pkg::NLP_PERIOD,
    parameter int NLP_HOLD      = eth_pkg::NLP_HOLD,
    parameter int IFG_CYCLES    = eth_pkg::IFG_CYCLES,
    parameter int START_TIMEOUT = eth_pkg::START_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic frame_req,
    input  logic frame_busy,
    output logic frame_ack,
    output logic frame_go,
    output logic nlp_go,
    output logic tx_sel,
    output logic led_tx,
    output logic err_timeout
);

    import eth_pkg::*;

    localparam int NLP_W = cnt_width(NLP_PERIOD);
    localparam int TMR_W = cnt_width(max3(NLP_HOLD, START_TIMEOUT, IFG_CYCLES));

    localparam logic [NLP_W-1:0] NLP_LAST = NLP_W'(NLP_PERIOD - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(NLP_HOLD - 1);
    localparam logic [TMR_W-1:0] START_LD = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] IFG_LD   = TMR_W'(IFG_CYCLES - 1);

    tx_sched_state_t state_q;
    tx_sched_state_t state_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    logic [NLP_W-1:0] nlp_cnt_q;
    logic             nlp_due;
    logic             nlp_clr;

    logic frame_go_q, frame_go_d;
    logic nlp_go_q,   nlp_go_d;
    logic tx_sel_q,   tx_sel_d;
    logic led_tx_q,   led_tx_d;
    logic err_q,      err_d;

    eth_tx_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign nlp_due = (nlp_cnt_q == NLP_LAST);

    // The link-pulse cadence restarts after a pulse and after any frame activity
    assign nlp_clr = nlp_go_q || ((state_q == ST_IFG) && (state_d == ST_IDLE));

    // Free-running link-pulse counter, saturating at the due value
    always_ff @(posedge clk) begin
        if (reset) begin
            nlp_cnt_q <= '0;
        end else if (nlp_clr) begin
            nlp_cnt_q <= '0;
        end else if (!nlp_due) begin
            nlp_cnt_q <= nlp_cnt_q + NLP_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the shared timer is loaded on entry to each timed state
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable && nlp_due) begin
                    state_d  = ST_NLP;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end else if (enable && frame_req) begin
                    state_d  = ST_FSTART;
                    tmr_load = 1'b1;
                    tmr_val  = START_LD;
                end
            end
            ST_NLP: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FSTART: begin
                if (frame_busy) begin
                    state_d = ST_FRAME;
                end else if (tmr_done) begin
                    state_d  = ST_IFG;
                    tmr_load = 1'b1;
                    tmr_val  = IFG_LD;
                end
            end
            ST_FRAME: begin
                if (!frame_busy) begin
                    state_d  = ST_IFG;
                    tmr_load = 1'b1;
                    tmr_val  = IFG_LD;
                end
            end
            ST_IFG: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs derived from the upcoming state so they register alongside it
    always_comb begin
        nlp_go_d   = (state_q == ST_IDLE) && (state_d == ST_NLP);
        frame_go_d = (state_q == ST_IDLE) && (state_d == ST_FSTART);
        tx_sel_d   = (state_d inside {ST_FSTART, ST_FRAME, ST_IFG});
        led_tx_d   = (state_d != ST_FRAME);
        err_d      = err_q || ((state_q == ST_FSTART) && (state_d == ST_IFG));
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_go_q <= 1'b0;
            nlp_go_q   <= 1'b0;
            tx_sel_q   <= 1'b0;
            led_tx_q   <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            frame_go_q <= frame_go_d;
            nlp_go_q   <= nlp_go_d;
            tx_sel_q   <= tx_sel_d;
            led_tx_q   <= led_tx_d;
            err_q      <= err_d;
        end
    end

    assign frame_go    = frame_go_q;
    assign frame_ack   = frame_go_q;
    assign nlp_go      = nlp_go_q;
    assign tx_sel      = tx_sel_q;
    assign led_tx      = led_tx_q;
    assign err_timeout = err_q;

endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Transmit-side scheduler for the 10BASE-T PHY, clocked on the 20 MHz PHY clock. It decides when the link-pulse generator (`nlp`) fires and when the frame serializer (`eth_frame`) is started. It keeps the 16 ms normal-link-pulse cadence, enforces the 9.6 µs inter-frame gap, and never lets a link pulse overlap frame data. It also drives the output-mux select and the TX activity LED, replacing the free-running pulse/frame coupling in the top level.

## Interface
Parameters:
- `NLP_PERIOD`, 320000: cycles between link pulses (16 ms at 20 MHz).
- `NLP_HOLD`, 4: cycles the NLP path owns the line after `nlp_go` (pulse is 2 cycles, plus 2 guard cycles).
- `IFG_CYCLES`, 192: idle cycles after a frame ends (9.6 µs).
- `START_TIMEOUT`, 64: cycles allowed from `frame_go` to `frame_busy` rising.

Ports:
- `clk` in 1: 20 MHz PHY clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: scheduler enable; when low, no new NLP or frame is launched.
- `frame_req` in 1: level request to send one frame; held until `frame_ack`.
- `frame_busy` in 1: serializer's `Tx_w`, high while frame bits are on the wire.
- `frame_ack` out 1: one-cycle pulse, request accepted; coincides with `frame_go`.
- `frame_go` out 1: one-cycle start pulse to `eth_frame.transmit`.
- `nlp_go` out 1: one-cycle trigger to `nlp.go`.
- `tx_sel` out 1: line-mux select; 0 = NLP path, 1 = frame path.
- `led_tx` out 1: active-low activity LED, low while in FRAME.
- `err_timeout` out 1: sticky flag; set when the frame start times out.

## Operation
- States: IDLE, NLP, FSTART, FRAME, IFG. Reset enters IDLE.
- `nlp_cnt` counts every cycle and saturates at `NLP_PERIOD-1`. `nlp_due` = (`nlp_cnt == NLP_PERIOD-1`).
- `nlp_cnt` clears on entry to NLP and on the IFG→IDLE transition. Frame activity counts as link activity.
- IDLE:
  - if `enable && nlp_due` → NLP. NLP has priority when `frame_req` is also high.
  - else if `enable && frame_req` → FSTART.
- NLP:
  - `nlp_go` = 1 on the first cycle only; `tx_sel` = 0.
  - After `NLP_HOLD` cycles → IDLE.
- FSTART:
  - On the first cycle, `frame_go` = `frame_ack` = 1 and `tx_sel` = 1.
  - `frame_busy` = 1 → FRAME.
  - `START_TIMEOUT` cycles without `frame_busy` → set `err_timeout`, then → IFG.
- FRAME: `tx_sel` = 1, `led_tx` = 0. `frame_busy` falling → IFG. No NLP is issued here, even if `nlp_due`.
- IFG: `tx_sel` = 1 (line idle). After `IFG_CYCLES` → IDLE.
- `enable` dropping mid-operation does not abort the current state; the scheduler returns to IDLE and stays there.
- Back-to-back frames: `frame_req` still high in IDLE after IFG gives a new FSTART, unless `nlp_due`.
- Counter widths are `$clog2(param)` bits. A single shared state-timer is reused across NLP, FSTART and IFG, sized to the largest of those parameters.

## Timing
- Reset values:
  - state IDLE; `nlp_cnt` = 0; `frame_ack` = `frame_go` = `nlp_go` = 0.
  - `tx_sel` = 0, `led_tx` = 1, `err_timeout` = 0.
- All outputs are registered. Latency from `frame_req` sampled high in IDLE to `frame_go` is 1 cycle.
- First NLP after reset: `nlp_go` is high in cycle `NLP_PERIOD+1`, counting from the first cycle with reset low.
- Period between successive NLPs with no frames is `NLP_PERIOD+1` cycles (entry into NLP plus count).
- `frame_go` to the next earliest `frame_go` is at least 1 + frame length + `IFG_CYCLES` + 1 cycles.
- `reset` asserted in any state returns to IDLE on the next edge. A frame in flight is abandoned; the serializer is reset by the same signal.

## Structure
- Package `eth_pkg`:
  - `tx_sched_state_t` enum.
  - 20 MHz timing constants (NLP_PERIOD, IFG_CYCLES), shared with `nlp` and `eth_frame`.
- Sub-module `eth_tx_timer`: loadable down-counter with a `done` flag, used as the shared state-timer. The free-running NLP counter stays inline.

## Test plan
Override for simulation: `NLP_PERIOD`=100, `IFG_CYCLES`=12, `START_TIMEOUT`=8.
- Idle with `enable`=1, no requests → `nlp_go` pulses at cycle 101, then every 101 cycles; `tx_sel`=0 throughout.
- `frame_req` at cycle 10; `frame_busy` high cycles 13–40 → `frame_go`/`frame_ack` at cycle 11, `led_tx`=0 during busy, return to IDLE 12 cycles after busy falls, next `nlp_go` 101 cycles later.
- `frame_req` rises in the same cycle `nlp_due` → `nlp_go` first, `frame_go` `NLP_HOLD`+1 cycles later.
- `nlp_due` reached while in FRAME → no `nlp_go` until after IFG.
- `frame_busy` never rises → `err_timeout`=1 eight cycles after `frame_go`, then IFG, then IDLE; the flag stays set until reset.
- `reset` pulsed during FRAME → all outputs at reset values next cycle; `enable`=0 blocks both `nlp_go` and `frame_go` indefinitely.
